mdio_txn_ctrl: RTL and testbench

- Transaction controller directly upstream of the MDIO master core. It owns that core's `start`/`conf`/`wr_data` inputs and consumes its `done`/`rd_data` outputs.
- Accepts clause-22 read/write requests from a host valid/ready port and returns responses.
- When no host request is pending, periodically auto-polls a PHY's BMSR (reg 1) and reports link status.
- Runs in the `clk` domain; `mdc` and `core_done` are synchronised in.

---
 rtl/mdio_txn_ctrl_if.sv | 30 +++
 rtl/mdio_txn_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mdio_txn_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_txn_ctrl_if.sv
// Host request/response port of mdio_txn_ctrl.
//   req_valid/req_ready : request handshake; a request is taken on valid & ready
//   req_write           : 1 = write, 0 = read
//   req_phy, req_reg    : clause-22 PHY and register address
//   req_wdata           : write data
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : read data (0 for writes and timeouts), held between pulses
//   resp_timeout        : qualifies resp_valid; transaction was aborted
// master = host side, slave = controller side.
interface mdio_txn_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [4:0]  req_phy;
  logic [4:0]  req_reg;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_timeout;

  modport master (
    output req_valid, req_write, req_phy, req_reg, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_timeout
  );

  modport slave (
    input  req_valid, req_write, req_phy, req_reg, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_timeout
  );
endinterface

// File: rtl/mdio_txn_ctrl.sv
// MDIO transaction controller sitting directly upstream of an MDIO master core.
// Takes clause-22 read/write requests from the host port, issues them to the
// core one at a time, and returns a response. With no host request pending it
// periodically reads BMSR (reg 1) of poll_phy and reports link status.
//
// Ports:
//   clk, arst_n        : system clock, asynchronous active-low reset
//   host               : request/response port (mdio_txn_ctrl_if.slave)
//   poll_en, poll_phy  : autopoll enable and PHY address
//   poll_rdata         : last good BMSR value
//   link_up            : poll_rdata[2]
//   link_change        : one-cycle pulse when link_up changes
//   mdc                : MDC from the core (monitored only, synchronised)
//   core_start         : start to the core
//   core_conf          : {op[1:0], phy[4:0], reg[4:0]}, read 2'b10, write 2'b01
//   core_wdata         : write data to the core
//   core_done          : done from the core (mdc domain, synchronised)
//   core_rdata         : read data from the core, stable once done is high
module mdio_txn_ctrl #(
  parameter int unsigned POLL_CYCLES    = 1000000,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic                 clk,
  input  logic                 arst_n,
  mdio_txn_ctrl_if.slave       host,
  input  logic                 poll_en,
  input  logic [4:0]           poll_phy,
  output logic [15:0]          poll_rdata,
  output logic                 link_up,
  output logic                 link_change,
  input  logic                 mdc,
  output logic                 core_start,
  output logic [11:0]          core_conf,
  output logic [15:0]          core_wdata,
  input  logic                 core_done,
  input  logic [15:0]          core_rdata
);

  localparam int unsigned TMR_W = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [4:0] BMSR  = 5'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_WAIT_DONE,
    ST_RESP
  } state_t;

  typedef enum logic {
    SRC_HOST,
    SRC_POLL
  } src_t;

  // ---------------------------------------------------------------------------
  // Synchronisers for the mdc-domain inputs
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] mdc_sync_q;
  logic [SYNC_STAGES-1:0] done_sync_q;
  logic                   mdc_dly_q;
  logic                   mdc_s;
  logic                   done_s;
  logic                   mdc_fall;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mdc_sync_q  <= '0;
      done_sync_q <= '0;
      mdc_dly_q   <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
      done_sync_q <= {done_sync_q[SYNC_STAGES-2:0], core_done};
      mdc_dly_q   <= mdc_s;
    end
  end

  assign mdc_s    = mdc_sync_q[SYNC_STAGES-1];
  assign done_s   = done_sync_q[SYNC_STAGES-1];
  assign mdc_fall = mdc_dly_q & ~mdc_s;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  src_t              src_q, src_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              fall_seen_q, fall_seen_d;
  logic [11:0]       conf_q, conf_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       data_q, data_d;
  logic              to_flag_q, to_flag_d;
  logic [15:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_timeout_q, resp_timeout_d;
  logic [15:0]       poll_rdata_q, poll_rdata_d;
  logic              link_change_q, link_change_d;

  logic              busy;
  logic              timed_out;
  logic              poll_due;
  logic              is_write;

  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT_ACK) ||
                     (state_q == ST_WAIT_DONE);
  assign timed_out = busy && (to_cnt_q == TO_LAST);
  assign poll_due  = poll_en && (timer_q == '0);
  assign is_write  = (conf_q[11:10] == OP_WR);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q        <= ST_IDLE;
      src_q          <= SRC_HOST;
      timer_q        <= TMR_RELOAD;
      to_cnt_q       <= '0;
      fall_seen_q    <= 1'b0;
      conf_q         <= '0;
      wdata_q        <= '0;
      data_q         <= '0;
      to_flag_q      <= 1'b0;
      resp_rdata_q   <= '0;
      resp_timeout_q <= 1'b0;
      poll_rdata_q   <= '0;
      link_change_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      timer_q        <= timer_d;
      to_cnt_q       <= to_cnt_d;
      fall_seen_q    <= fall_seen_d;
      conf_q         <= conf_d;
      wdata_q        <= wdata_d;
      data_q         <= data_d;
      to_flag_q      <= to_flag_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_timeout_q <= resp_timeout_d;
      poll_rdata_q   <= poll_rdata_d;
      link_change_q  <= link_change_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    timer_d        = timer_q;
    to_cnt_d       = to_cnt_q;
    fall_seen_d    = fall_seen_q;
    conf_d         = conf_q;
    wdata_d        = wdata_q;
    data_d         = data_q;
    to_flag_d      = to_flag_q;
    resp_rdata_d   = resp_rdata_q;
    resp_timeout_d = resp_timeout_q;
    poll_rdata_d   = poll_rdata_q;
    link_change_d  = 1'b0;

    // Poll interval timer: counts only while idle, so a host transaction that
    // wins arbitration leaves an expired timer at 0 for the next idle cycle.
    if (!poll_en || ((state_q == ST_RESP) && (src_q == SRC_POLL))) begin
      timer_d = TMR_RELOAD;
    end else if ((state_q == ST_IDLE) && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end

    if (busy) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (host.req_valid) begin
          conf_d      = {host.req_write ? OP_WR : OP_RD, host.req_phy, host.req_reg};
          wdata_d     = host.req_wdata;
          src_d       = SRC_HOST;
          to_cnt_d    = '0;
          fall_seen_d = 1'b0;
          to_flag_d   = 1'b0;
          state_d     = ST_ISSUE;
        end else if (poll_due) begin
          conf_d      = {OP_RD, poll_phy, BMSR};
          wdata_d     = '0;
          src_d       = SRC_POLL;
          to_cnt_d    = '0;
          fall_seen_d = 1'b0;
          to_flag_d   = 1'b0;
          state_d     = ST_ISSUE;
        end
      end

      // Hold start across two MDC falling edges so the core sees it on a
      // clean negedge regardless of where start rose within the MDC period.
      ST_ISSUE: begin
        if (mdc_fall) begin
          if (fall_seen_q) begin
            state_d = ST_WAIT_ACK;
          end else begin
            fall_seen_d = 1'b1;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (!done_s) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        if (done_s) begin
          data_d  = is_write ? '0 : core_rdata;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        if ((src_q == SRC_POLL) && !to_flag_q) begin
          poll_rdata_d  = data_q;
          link_change_d = data_q[2] ^ poll_rdata_q[2];
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Timeout overrides whatever the busy state decided this cycle.
    if (timed_out) begin
      data_d    = '0;
      to_flag_d = 1'b1;
      state_d   = ST_RESP;
    end

    // Host response registers load on the edge into RESP so that they are
    // already valid during the resp_valid cycle and hold afterwards.
    if ((state_d == ST_RESP) && (state_q != ST_RESP) && (src_q == SRC_HOST)) begin
      resp_rdata_d   = data_d;
      resp_timeout_d = to_flag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign host.req_ready    = (state_q == ST_IDLE);
  assign host.resp_valid   = (state_q == ST_RESP) && (src_q == SRC_HOST);
  assign host.resp_rdata   = resp_rdata_q;
  assign host.resp_timeout = resp_timeout_q;

  assign core_start  = (state_q == ST_ISSUE);
  assign core_conf   = conf_q;
  assign core_wdata  = wdata_q;

  assign poll_rdata  = poll_rdata_q;
  assign link_up     = poll_rdata_q[2];
  assign link_change = link_change_q;

endmodule

// File: tb/tb_mdio_txn_ctrl.sv
module tb_mdio_txn_ctrl;
  localparam int POLL = 64;
  localparam int TO   = 200;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        poll_en;
  logic [4:0]  poll_phy;
  logic [15:0] poll_rdata;
  logic        link_up;
  logic        link_change;
  logic        mdc;
  logic        core_start;
  logic [11:0] core_conf;
  logic [15:0] core_wdata;
  logic        core_done;
  logic [15:0] core_rdata;

  mdio_txn_ctrl_if host ();

  mdio_txn_ctrl #(
    .POLL_CYCLES   (POLL),
    .TIMEOUT_CYCLES(TO),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .host       (host),
    .poll_en    (poll_en),
    .poll_phy   (poll_phy),
    .poll_rdata (poll_rdata),
    .link_up    (link_up),
    .link_change(link_change),
    .mdc        (mdc),
    .core_start (core_start),
    .core_conf  (core_conf),
    .core_wdata (core_wdata),
    .core_done  (core_done),
    .core_rdata (core_rdata)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------------------------------------------------------------------
  // MDC source (period 8 clk) and behavioural MDIO core
  // ---------------------------------------------------------------------------
  logic [15:0] core_resp_val = '0;
  int          core_delay = 20;
  logic        core_hang = 1'b0;

  initial begin
    mdc = 1'b0;
    forever begin
      repeat (4) @(negedge clk);
      mdc = ~mdc;
    end
  end

  // The core takes start on an MDC falling edge, drops done while busy and
  // raises it again with the read data; a hung core gives up long after the
  // controller's timeout.
  initial begin
    core_done  = 1'b1;
    core_rdata = '0;
    forever begin
      @(negedge mdc);
      if (core_start) begin
        core_done = 1'b0;
        if (core_hang) begin
          repeat (TO + 40) @(negedge clk);
        end else begin
          repeat (core_delay) @(negedge clk);
          core_rdata = core_resp_val;
        end
        core_done = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: sampled 1 time unit after each rising edge
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  logic        mdc_prev = 1'b0;
  logic        start_prev = 1'b0;
  logic        ready_prev = 1'b0;
  int          fall_q[$];
  int          start_cyc = 0;
  int          n_starts = 0;
  logic [11:0] start_conf = '0;
  logic [15:0] start_wdata = '0;
  int          last_ready_rise = 0;
  int          resp_cnt = 0;
  int          resp_cyc = 0;
  logic [15:0] resp_rdata_seen = '0;
  logic        resp_to_seen = 1'b0;
  int          lchg_cnt = 0;
  int          nf;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (mdc_prev && !mdc) begin
      fall_q.push_back(cyc);
      if (fall_q.size() > 8) fall_q.delete(0);
    end
    if (core_start && !start_prev) begin
      start_cyc   = cyc;
      start_conf  = core_conf;
      start_wdata = core_wdata;
      n_starts++;
    end
    // A raw MDC fall captured at edge n is acted on SYNC edges later; start
    // must cover exactly two such falls.
    if (!core_start && start_prev && arst_n) begin
      nf = 0;
      foreach (fall_q[i])
        if (fall_q[i] >= start_cyc + 1 - SYNC && fall_q[i] <= cyc - SYNC) nf++;
      check_eq("start_mdc_falls", nf, 2);
    end
    if (host.req_ready && !ready_prev) last_ready_rise = cyc;
    if (host.resp_valid) begin
      resp_cnt++;
      resp_cyc        = cyc;
      resp_rdata_seen = host.resp_rdata;
      resp_to_seen    = host.resp_timeout;
    end
    if (link_change) lchg_cnt++;
    mdc_prev   = mdc;
    start_prev = core_start;
    ready_prev = host.req_ready;
  end

  // ---------------------------------------------------------------------------
  // Host transaction with reference expectations
  // ---------------------------------------------------------------------------
  task automatic host_txn(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                          input logic [15:0] wd, input logic [15:0] data, input int delay,
                          input logic hang, input int at_cyc);
    int          g;
    int          s0;
    int          r0;
    int          ready_hi;
    logic [11:0] exp_conf;
    logic [15:0] exp_rd;
    core_resp_val = data;
    core_delay    = delay;
    core_hang     = hang;
    g = 0;
    while (!core_done && g < 1000) begin @(negedge clk); g++; end
    check_eq("core_idle", core_done, 1);
    while (cyc < at_cyc) @(negedge clk);
    s0 = n_starts;
    r0 = resp_cnt;
    host.req_write = wr;
    host.req_phy   = phy;
    host.req_reg   = rg;
    host.req_wdata = wd;
    host.req_valid = 1'b1;
    g = 0;
    while (!host.req_ready && g < 1000) begin @(negedge clk); g++; end
    @(negedge clk);
    host.req_valid = 1'b0;
    g = 0;
    while (n_starts == s0 && g < 100) begin @(negedge clk); g++; end
    check_eq("start_seen", n_starts - s0, 1);
    exp_conf = {wr ? 2'b01 : 2'b10, phy, rg};
    check_eq("host_conf", start_conf, exp_conf);
    check_eq("host_wdata", start_wdata, wd);
    ready_hi = 0;
    g = 0;
    while (resp_cnt == r0 && g < TO + 100) begin
      if (host.req_ready) ready_hi++;
      @(negedge clk);
      g++;
    end
    check_eq("resp_seen", resp_cnt - r0, 1);
    check_eq("ready_low_busy", ready_hi, 0);
    exp_rd = (wr || hang) ? 16'h0000 : data;
    check_eq("resp_rdata", resp_rdata_seen, exp_rd);
    check_eq("resp_timeout", resp_to_seen, hang);
    if (hang) check_eq("timeout_latency", resp_cyc - start_cyc, TO);
    @(negedge clk);
    check_eq("resp_single_pulse", host.resp_valid, 0);
    check_eq("ready_after_resp", host.req_ready, 1);
    check_eq("resp_rdata_hold", host.resp_rdata, exp_rd);
  endtask

  // Waits for the next autopoll, serves it with value v and checks the
  // published result against the running link model.
  logic model_link = 1'b0;

  task automatic poll_txn(input logic [15:0] v, input logic check_gap, input int exp_start);
    int g;
    int s0;
    int lc0;
    int r0;
    int prev_rise;
    prev_rise = last_ready_rise;
    s0 = n_starts;
    r0 = resp_cnt;
    lc0 = lchg_cnt;
    g = 0;
    while (n_starts == s0 && g < POLL + 100) begin @(negedge clk); g++; end
    check_eq("poll_start_seen", n_starts - s0, 1);
    core_resp_val = v;
    core_delay    = 20 + int'($urandom_range(0, 20));
    check_eq("poll_conf", start_conf, {2'b10, poll_phy, 5'd1});
    check_eq("poll_wdata", start_wdata, 0);
    if (check_gap) check_eq("poll_interval", start_cyc - prev_rise, POLL);
    if (exp_start >= 0) check_eq("poll_start_cyc", start_cyc, exp_start);
    g = 0;
    while (last_ready_rise <= start_cyc && g < TO + 100) begin @(negedge clk); g++; end
    check_eq("poll_done_seen", last_ready_rise > start_cyc, 1);
    check_eq("poll_rdata", poll_rdata, v);
    check_eq("link_up", link_up, v[2]);
    check_eq("link_change_cnt", lchg_cnt - lc0, (v[2] != model_link) ? 1 : 0);
    check_eq("poll_no_resp", resp_cnt - r0, 0);
    model_link = v[2];
    @(negedge clk);
    check_eq("link_change_pulse", link_change, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int          g;
    int          coll_r;
    logic [15:0] v;
    poll_en        = 1'b0;
    poll_phy       = 5'h1F;
    host.req_valid = 1'b0;
    host.req_write = 1'b0;
    host.req_phy   = '0;
    host.req_reg   = '0;
    host.req_wdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_core_start", core_start, 0);
    check_eq("rst_core_conf", core_conf, 0);
    check_eq("rst_resp_valid", host.resp_valid, 0);
    check_eq("rst_resp_rdata", host.resp_rdata, 0);
    check_eq("rst_poll_rdata", poll_rdata, 0);
    check_eq("rst_link", {link_up, link_change}, 0);
    arst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("ready_after_rst", host.req_ready, 1);

    // Directed host write and read
    host_txn(1'b1, 5'h03, 5'h00, 16'h8000, 16'hFFFF, 30, 1'b0, 0);
    check_eq("write_conf_460", start_conf, 12'h460);
    host_txn(1'b0, 5'h01, 5'h02, 16'h0000, 16'h0141, 25, 1'b0, 0);
    check_eq("read_conf_822", start_conf, 12'h822);

    // Random host traffic
    for (int i = 0; i < 10; i++) begin
      host_txn(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
               16'($urandom), int'($urandom_range(20, 60)), 1'b0, 0);
    end

    // Autopoll: link comes up on the second poll, then random BMSR values
    @(negedge clk);
    poll_en = 1'b1;
    poll_txn(16'h7849, 1'b0, -1);
    poll_txn(16'h796D, 1'b1, -1);
    for (int i = 0; i < 3; i++) begin
      v = 16'($urandom);
      poll_txn(v, 1'b1, -1);
    end

    // Collision: request lands in the cycle the next poll falls due
    coll_r = last_ready_rise;
    host_txn(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
             16'($urandom), 30, 1'b0, coll_r + POLL - 1);
    check_eq("collide_host_first", start_cyc, coll_r + POLL);
    v = 16'($urandom) | 16'h0004;
    poll_txn(v, 1'b0, last_ready_rise + 1);
    poll_en = 1'b0;

    // Timeout: core never completes
    host_txn(1'b0, 5'($urandom), 5'($urandom), 16'h0000, 16'hABCD, 0, 1'b1, 0);

    // Reset while waiting for done
    check_eq("link_before_rst", link_up, 1);
    g = 0;
    while (!core_done && g < 1000) begin @(negedge clk); g++; end
    core_resp_val  = 16'h1234;
    core_delay     = 80;
    core_hang      = 1'b0;
    host.req_write = 1'b0;
    host.req_phy   = 5'h02;
    host.req_reg   = 5'h03;
    host.req_valid = 1'b1;
    @(negedge clk);
    host.req_valid = 1'b0;
    g = 0;
    while (!core_start && g < 20) begin @(negedge clk); g++; end
    g = 0;
    while (core_start && g < 100) begin @(negedge clk); g++; end
    repeat (6) @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    check_eq("mid_rst_core_start", core_start, 0);
    check_eq("mid_rst_link_up", link_up, 0);
    check_eq("mid_rst_poll_rdata", poll_rdata, 0);
    check_eq("mid_rst_core_conf", core_conf, 0);
    check_eq("mid_rst_resp_valid", host.resp_valid, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    host_txn(1'b0, 5'h04, 5'h05, 16'h0000, 16'h5A5A, 30, 1'b0, 0);

    // Reset during ISSUE must drop start before any clock edge
    host.req_write = 1'b1;
    host.req_valid = 1'b1;
    @(negedge clk);
    host.req_valid = 1'b0;
    check_eq("issue_start_high", core_start, 1);
    #2 arst_n = 1'b0;
    #1 check_eq("async_start_drop", core_start, 0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    host_txn(1'b1, 5'h1E, 5'h1D, 16'hC3C3, 16'h0000, 25, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
